fft_r22sdf_tw_mult: RTL and testbench



---
 rtl/fft_pkg.sv | 24 ++
 rtl/fft_twiddle_rom.sv | 38 +++
 rtl/fft_r22sdf_tw_mult.sv | 113 +++++++++++
 tb/tb_fft_r22sdf_tw_mult.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants and helpers for the R2^2 SDF FFT twiddle-multiply stages.
package fft_pkg;

  // Exponent multiplier per quarter of the span: e = m * {0,2,1,3}[q]
  localparam logic [1:0] QUARTER_MULT [4] = '{2'd0, 2'd2, 2'd1, 2'd3};

  function automatic logic [1:0] quarter_mult(input logic [1:0] q);
    return QUARTER_MULT[q];
  endfunction

  function automatic int prod_width(input int dw, input int tw);
    return dw + tw;
  endfunction

  function automatic int sum_width(input int dw, input int tw);
    return dw + tw + 1;
  endfunction

  // Half an output LSB once the product is scaled back by 2^(tw-1)
  function automatic longint round_const(input int tw);
    return 64'sd1 <<< (tw - 2);
  endfunction

endpackage

// File: rtl/fft_twiddle_rom.sv
// Twiddle ROM, L entries of {cos, -sin} at scale 2^(TW_WIDTH-1)-1, 1-cycle registered read.
module fft_twiddle_rom #(
  parameter int L            = 256,
  parameter int TW_WIDTH     = 10,
  parameter     TWIDDLE_FILE = "tw.hex"
) (
  input  logic                   i_clk,
  input  logic [$clog2(L)-1:0]   i_addr,
  output logic [2*TW_WIDTH-1:0]  o_tw
);

  localparam real PI    = 3.14159265358979323846;
  localparam real SCALE = real'((1 << (TW_WIDTH - 1)) - 1);

  function automatic logic [TW_WIDTH-1:0] round_tw(input real x);
    if (x >= 0.0) return TW_WIDTH'($rtoi(x + 0.5));
    return TW_WIDTH'(-$rtoi(0.5 - x));
  endfunction

  logic [2*TW_WIDTH-1:0] w_rom [L];
  logic [2*TW_WIDTH-1:0] r_tw;

  // Contents follow the same formula as the hex file, so builds without it get an identical table.
  if (TWIDDLE_FILE == "") begin : g_no_file
  end

  for (genvar k = 0; k < L; k++) begin : g_rom
    localparam real ANG = 2.0 * PI * real'(k) / real'(L);
    assign w_rom[k] = {round_tw(SCALE * $cos(ANG)), round_tw(-SCALE * $sin(ANG))};
  end

  always_ff @(posedge i_clk) begin
    r_tw <= w_rom[i_addr];
  end

  assign o_tw = r_tw;

endmodule

// File: rtl/fft_r22sdf_tw_mult.sv
// R2^2 SDF inter-stage twiddle multiplier: fixed 4-cycle latency, no backpressure.
// Define FFT_TW_MULT_SAT_EN to saturate instead of wrap when narrowing the product.
module fft_r22sdf_tw_mult
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH   = 25,
  parameter int TW_WIDTH     = 10,
  parameter int SPAN_LEN     = 256,
  parameter     TWIDDLE_FILE = "tw.hex"
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] x_re_i,
  input  logic [DATA_WIDTH-1:0] x_im_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] z_re_o,
  output logic [DATA_WIDTH-1:0] z_im_o
);

  localparam int LW = $clog2(SPAN_LEN);
  localparam int PW = prod_width(DATA_WIDTH, TW_WIDTH);
  localparam int SW = sum_width(DATA_WIDTH, TW_WIDTH);
  localparam int OW = SW - (TW_WIDTH - 1);
  localparam logic signed [SW-1:0] RND = SW'(round_const(TW_WIDTH));

  logic [LW-1:0]                r_cnt, r1_e, w_m, w_e;
  logic [1:0]                   w_q;
  logic                         r1_valid, r2_valid, r3_valid, r_valid_o;
  logic                         r1_byp, r2_byp, r3_byp;
  logic signed [DATA_WIDTH-1:0] r1_re, r1_im, r2_re, r2_im, r3_re, r3_im, r_z_re, r_z_im;
  logic signed [PW-1:0]         r3_ac, r3_bd, r3_ad, r3_bc;
  logic [2*TW_WIDTH-1:0]        w_tw;
  logic signed [TW_WIDTH-1:0]   w_c, w_d;
  logic signed [SW-1:0]         w_re_sum, w_im_sum;
  logic signed [OW-1:0]         w_re_rnd, w_im_rnd;

  assign w_q = r_cnt[LW-1 -: 2];
  assign w_m = r_cnt & LW'(SPAN_LEN / 4 - 1);
  assign w_e = w_m * LW'(quarter_mult(w_q));

  fft_twiddle_rom #(
    .L            (SPAN_LEN),
    .TW_WIDTH     (TW_WIDTH),
    .TWIDDLE_FILE (TWIDDLE_FILE)
  ) u_rom (
    .i_clk  (clk_i),
    .i_addr (r1_e),
    .o_tw   (w_tw)
  );

  assign w_c = w_tw[2*TW_WIDTH-1:TW_WIDTH];
  assign w_d = w_tw[TW_WIDTH-1:0];

  assign w_re_sum = SW'(r3_ac) - SW'(r3_bd) + RND;
  assign w_im_sum = SW'(r3_ad) + SW'(r3_bc) + RND;
  assign w_re_rnd = OW'(w_re_sum >>> (TW_WIDTH - 1));
  assign w_im_rnd = OW'(w_im_sum >>> (TW_WIDTH - 1));

  function automatic logic signed [DATA_WIDTH-1:0] narrow(input logic signed [OW-1:0] v);
`ifdef FFT_TW_MULT_SAT_EN
    if (&v[OW-1:DATA_WIDTH-1] || ~|v[OW-1:DATA_WIDTH-1]) return v[DATA_WIDTH-1:0];
    return v[OW-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
`else
    return DATA_WIDTH'(v);
`endif
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt     <= '0;
      r1_valid  <= 1'b0;
      r2_valid  <= 1'b0;
      r3_valid  <= 1'b0;
      r_valid_o <= 1'b0;
      r_z_re    <= '0;
      r_z_im    <= '0;
    end else begin
      if (valid_i) r_cnt <= r_cnt + LW'(1);
      r1_valid  <= valid_i;
      r2_valid  <= r1_valid;
      r3_valid  <= r2_valid;
      r_valid_o <= r3_valid;
      // e == 0 passes data straight through to avoid the 511/512 gain loss
      if (r3_valid) begin
        r_z_re <= r3_byp ? r3_re : narrow(w_re_rnd);
        r_z_im <= r3_byp ? r3_im : narrow(w_im_rnd);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    r1_re  <= $signed(x_re_i);
    r1_im  <= $signed(x_im_i);
    r1_e   <= w_e;
    r1_byp <= (w_e == '0);
    r2_re  <= r1_re;
    r2_im  <= r1_im;
    r2_byp <= r1_byp;
    r3_re  <= r2_re;
    r3_im  <= r2_im;
    r3_byp <= r2_byp;
    r3_ac  <= PW'(r2_re) * PW'(w_c);
    r3_bd  <= PW'(r2_im) * PW'(w_d);
    r3_ad  <= PW'(r2_re) * PW'(w_d);
    r3_bc  <= PW'(r2_im) * PW'(w_c);
  end

  assign valid_o = r_valid_o;
  assign z_re_o  = r_z_re;
  assign z_im_o  = r_z_im;

endmodule

// File: tb/tb_fft_r22sdf_tw_mult.sv
// Scoreboard bench: two spans (L=16, L=64) share one stimulus stream, checked against a math model.
`timescale 1ns/1ps
module tb_fft_r22sdf_tw_mult;

  localparam int DW   = 25;
  localparam int TW   = 10;
  localparam int NDUT = 2;
  localparam int LEN [NDUT] = '{16, 64};
  localparam logic [DW-1:0] PMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] NMIN = {1'b1, {(DW-1){1'b0}}};

  typedef struct {
    longint re;
    longint im;
    int     cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst, vin;
  logic [DW-1:0] xre, xim;
  logic          vout [NDUT];
  logic [DW-1:0] zre [NDUT];
  logic [DW-1:0] zim [NDUT];

  exp_t   sbq [NDUT][$];
  int     n_model [NDUT];
  longint last_re [NDUT];
  longint last_im [NDUT];
  int     cyc = 0;
  int     checks = 0;
  int     errors = 0;
  bit     mon_en = 1'b0;
  exp_t   mx;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft_r22sdf_tw_mult #(.DATA_WIDTH(DW), .TW_WIDTH(TW), .SPAN_LEN(16)) u_dut16 (
    .clk_i(clk), .rst_i(rst), .valid_i(vin), .x_re_i(xre), .x_im_i(xim),
    .valid_o(vout[0]), .z_re_o(zre[0]), .z_im_o(zim[0])
  );

  fft_r22sdf_tw_mult #(.DATA_WIDTH(DW), .TW_WIDTH(TW), .SPAN_LEN(64)) u_dut64 (
    .clk_i(clk), .rst_i(rst), .valid_i(vin), .x_re_i(xre), .x_im_i(xim),
    .valid_o(vout[1]), .z_re_o(zre[1]), .z_im_o(zim[1])
  );

  function automatic longint round_real(input real x);
    if (x >= 0.0) return longint'($rtoi(x + 0.5));
    return -longint'($rtoi(0.5 - x));
  endfunction

  function automatic longint fit(input longint v);
    longint w;
    w = v & ((64'sd1 <<< DW) - 1);
`ifdef FFT_TW_MULT_SAT_EN
    if (v > (64'sd1 <<< (DW - 1)) - 1) return (64'sd1 <<< (DW - 1)) - 1;
    if (v < -(64'sd1 <<< (DW - 1))) return -(64'sd1 <<< (DW - 1));
    return v;
`else
    return (w >= (64'sd1 <<< (DW - 1))) ? w - (64'sd1 <<< DW) : w;
`endif
  endfunction

  // x * W_L^e, with e derived from the sample's position n in the span
  function automatic void model(input int L, input int n, input longint a, input longint b,
                                output longint er, output longint ei);
    int     mult [4] = '{0, 2, 1, 3};
    int     e;
    real    ang, scale;
    longint c, d, half;
    e = (n % (L / 4)) * mult[n / (L / 4)];
    if (e == 0) begin
      er = a;
      ei = b;
      return;
    end
    scale = real'((1 << (TW - 1)) - 1);
    half  = 64'sd1 <<< (TW - 2);
    ang   = 2.0 * 3.14159265358979323846 * real'(e) / real'(L);
    c     = round_real(scale * $cos(ang));
    d     = round_real(-scale * $sin(ang));
    er    = fit((a * c - b * d + half) >>> (TW - 1));
    ei    = fit((a * d + b * c + half) >>> (TW - 1));
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    if ($urandom_range(0, 1) == 1) return DW'($urandom);
    return DW'($signed(21'($urandom)));
  endfunction

  // Called just after a rising edge; the sample is captured on the next one.
  task automatic drive(input logic v, input logic [DW-1:0] re, input logic [DW-1:0] im);
    exp_t x;
    vin = v;
    xre = re;
    xim = im;
    if (v) begin
      for (int i = 0; i < NDUT; i++) begin
        model(LEN[i], n_model[i], longint'($signed(re)), longint'($signed(im)), x.re, x.im);
        x.cyc = cyc;
        sbq[i].push_back(x);
        n_model[i] = (n_model[i] + 1) % LEN[i];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int ncyc);
    rst = 1'b1;
    vin = 1'b0;
    repeat (ncyc) @(posedge clk);
    #1;
    for (int i = 0; i < NDUT; i++) begin
      sbq[i].delete();
      n_model[i] = 0;
      last_re[i] = 0;
      last_im[i] = 0;
      checks++;
      if (vout[i] !== 1'b0 || zre[i] !== '0 || zim[i] !== '0) begin
        errors++;
        $display("FAIL reset_state dut%0d got valid=%b re=%0d im=%0d, want 0 0 0",
                 i, vout[i], $signed(zre[i]), $signed(zim[i]));
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        for (int i = 0; i < NDUT; i++) begin
          checks++;
          if (vout[i] === 1'b1) begin
            if (sbq[i].size() == 0) begin
              errors++;
              $display("FAIL unexpected_out dut%0d got valid with no sample pending at cycle %0d", i, cyc);
            end else begin
              mx = sbq[i].pop_front();
              if (longint'($signed(zre[i])) != mx.re || longint'($signed(zim[i])) != mx.im
                  || cyc - mx.cyc != 4) begin
                errors++;
                $display("FAIL out_dut%0d got (%0d,%0d) latency %0d, want (%0d,%0d) latency 4",
                         i, $signed(zre[i]), $signed(zim[i]), cyc - mx.cyc, mx.re, mx.im);
              end
              last_re[i] = mx.re;
              last_im[i] = mx.im;
            end
          end else if (vout[i] !== 1'b0 || longint'($signed(zre[i])) != last_re[i]
                       || longint'($signed(zim[i])) != last_im[i]) begin
            errors++;
            $display("FAIL hold_dut%0d got valid=%b (%0d,%0d), want valid=0 (%0d,%0d)",
                     i, vout[i], $signed(zre[i]), $signed(zim[i]), last_re[i], last_im[i]);
          end
        end
      end
    end
  end

  initial begin
    int  sent;
    logic v;
    rst = 1'b1;
    vin = 1'b0;
    xre = '0;
    xim = '0;
    do_reset(3);
    mon_en = 1'b1;

    repeat (16) drive(1'b1, DW'(1000), DW'(0));
    repeat (6) drive(1'b0, '0, '0);

    for (int k = 0; k < 32; k++) drive((k % 2) == 0, rnd_data(), rnd_data());

    // reset lands with the 16-point span at n=9
    for (int k = 0; k < 9; k++) drive(1'b1, rnd_data(), rnd_data());
    do_reset(1);
    drive(1'b1, DW'(12345), DW'(-777));

    for (int k = 0; k < 14; k++) drive(1'b1, rnd_data(), rnd_data());
    drive(1'b1, PMAX, PMAX);
    for (int k = 0; k < 15; k++) drive(1'b1, rnd_data(), rnd_data());
    drive(1'b1, NMIN, NMIN);
    for (int k = 0; k < 15; k++) drive(1'b1, rnd_data(), rnd_data());
    drive(1'b1, PMAX, NMIN);
    repeat (3) drive(1'b0, '0, '0);

    sent = 0;
    while (sent < 256) begin
      v = ($urandom_range(0, 3) != 0);
      drive(v, rnd_data(), rnd_data());
      if (v) sent++;
    end
    repeat (8) drive(1'b0, '0, '0);

    for (int i = 0; i < NDUT; i++) begin
      checks++;
      if (sbq[i].size() != 0) begin
        errors++;
        $display("FAIL drain_dut%0d got %0d samples never output, want 0", i, sbq[i].size());
      end
    end

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
